// File: rtl/unique_stream_packer.sv
// unique_stream_packer: captures an N-element frame plus keep mask and streams the
// kept elements in ascending index order, then reports how many were emitted.
module unique_stream_packer #(
   parameter int  N     = 8,
   parameter int  WIDTH = 8,
   localparam int IW    = $clog2(N),
   localparam int CW    = $clog2(N + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N-1:0][WIDTH-1:0]   in_arr,
   input  logic [N-1:0]              in_keep,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [IW-1:0]             out_index,
   output logic                      out_last,
   output logic                      frame_done,
   output logic [CW-1:0]             kept_count
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                  state_q, state_d;
   logic [N-1:0][WIDTH-1:0] arr_q;
   logic [N-1:0]            mask_q;
   logic [N-1:0]            rest;
   logic [CW-1:0]           count_q;
   logic [CW-1:0]           kept_count_q;
   logic                    frame_done_q;
   logic                    pend_q;
   logic [IW-1:0]           ptr;
   logic [IW-1:0]           idx;
   logic                    last;
   logic                    beat;
   logic                    accept;
   logic                    empty_in;

   // Lowest set bit of the pending mask selects the next element.
   always_comb begin
      ptr = '0;
      idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = IW'(N - 1 - i);
         if (mask_q[idx]) ptr = idx;
      end
      rest      = mask_q;
      rest[ptr] = 1'b0;
      last      = (rest == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (beat && last) state_d = IDLE;
      if (accept)       state_d = empty_in ? IDLE : STREAM;
   end

   always_comb begin
      out_valid = (state_q == STREAM);
      out_data  = out_valid ? arr_q[ptr] : '0;
      out_index = out_valid ? ptr : '0;
      out_last  = out_valid && last;
      in_ready  = !rst && ((state_q == IDLE) || (out_valid && out_ready && last));
      beat      = out_valid && out_ready;
      accept    = in_valid && in_ready;
      empty_in  = (in_keep == '0);
   end

   // An empty frame accepted on another frame's last beat would pulse frame_done in the
   // same cycle; pend_q defers its zero-count pulse by one cycle so both are reported.
   always_ff @(posedge clk) begin
      if (rst) begin
         arr_q        <= '0;
         mask_q       <= '0;
         count_q      <= '0;
         frame_done_q <= 1'b0;
         kept_count_q <= '0;
         pend_q       <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (beat) begin
            mask_q  <= rest;
            count_q <= count_q + CW'(1);
         end
         if (accept) begin
            arr_q   <= in_arr;
            mask_q  <= in_keep;
            count_q <= '0;
         end
         if (beat && last) begin
            frame_done_q <= 1'b1;
            kept_count_q <= count_q + CW'(1);
            pend_q       <= accept && empty_in;
         end else if (pend_q || (accept && empty_in)) begin
            frame_done_q <= 1'b1;
            kept_count_q <= '0;
            pend_q       <= pend_q && accept && empty_in;
         end
      end
   end

   assign frame_done = frame_done_q;
   assign kept_count = kept_count_q;

endmodule

// File: tb/tb_unique_stream_packer.sv
// Bench for unique_stream_packer: queue-based frame model checked every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_unique_stream_packer;
   localparam int N     = 8;
   localparam int WIDTH = 8;
   localparam int IW    = $clog2(N);
   localparam int CW    = $clog2(N + 1);

   typedef logic [N-1:0][WIDTH-1:0] frame_t;
   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic [IW-1:0]    i;
      logic             l;
   } beat_t;

   logic             clk       = 1'b0;
   logic             rst       = 1'b1;
   logic             in_valid  = 1'b0;
   logic             out_ready = 1'b0;
   frame_t           in_arr    = '0;
   logic [N-1:0]     in_keep   = '0;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [IW-1:0]    out_index;
   logic             out_last;
   logic             frame_done;
   logic [CW-1:0]    kept_count;

   int    checks = 0;
   int    fails  = 0;
   bit    en     = 1'b0;
   bit    rnd_or = 1'b0;
   bit    rst_d  = 1'b0;
   beat_t exp_q[$];
   beat_t log_q[$];
   beat_t lit_q[$];
   int    done_log[$];
   int    lit_done[$];
   logic  exp_done = 1'b0;
   int    exp_cnt  = 0;
   int    served   = 0;

   unique_stream_packer #(.N(N), .WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_arr     (in_arr),
      .in_keep    (in_keep),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_index  (out_index),
      .out_last   (out_last),
      .frame_done (frame_done),
      .kept_count (kept_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic beat_t mk(input logic [WIDTH-1:0] d, input int i, input logic l);
      beat_t b;
      b.d = d;
      b.i = IW'(i);
      b.l = l;
      return b;
   endfunction

   // Model: a frame becomes the ordered list of its kept elements; one leaves per ready cycle.
   always @(negedge clk) begin
      beat_t b;
      logic  rdy;
      logic  nd;
      int    nc;
      if (en) begin
         rdy = !rst && (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready));
         chk("in_ready", in_ready, rdy);
         chk("out_valid", out_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            chk("out_data", out_data, exp_q[0].d);
            chk("out_index", out_index, exp_q[0].i);
            chk("out_last", out_last, exp_q[0].l);
         end
         chk("frame_done", frame_done, exp_done);
         if (exp_done) chk("kept_count", kept_count, exp_cnt);
         if (rst_d) chk("kept_count_after_rst", kept_count, 0);
         if (!rst && out_valid && out_ready) log_q.push_back(mk(out_data, int'(out_index), out_last));
         if (frame_done) done_log.push_back(int'(kept_count));
         rst_d = rst;
         if (rst) begin
            exp_q.delete();
            exp_done = 1'b0;
            exp_cnt  = 0;
            served   = 0;
         end else begin
            nd = 1'b0;
            nc = 0;
            if (exp_q.size() != 0 && out_ready) begin
               b = exp_q.pop_front();
               served++;
               if (b.l) begin
                  nd = 1'b1;
                  nc = served;
               end
            end
            if (in_valid && rdy) begin
               served = 0;
               for (int i = 0; i < N; i++)
                  if (in_keep[i]) exp_q.push_back(mk(in_arr[i], i, (in_keep >> (i + 1)) == '0));
               if (in_keep == '0) begin
                  nd = 1'b1;
                  nc = 0;
               end
            end
            exp_done = nd;
            exp_cnt  = nc;
         end
      end
   end

   always @(posedge clk) begin
      if (rnd_or) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input frame_t a, input logic [N-1:0] k);
      bit acc;
      acc      = 1'b0;
      in_arr   = a;
      in_keep  = k;
      in_valid = 1'b1;
      for (int c = 0; c < 200 && !acc; c++) begin
         @(negedge clk);
         acc = in_ready;
         tick();
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         fails++;
         $display("FAIL accept_timeout: in_ready stayed 0, required 1");
      end
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (out_valid && c < 300) begin
         tick();
         c++;
      end
      if (out_valid) begin
         checks++;
         fails++;
         $display("FAIL drain_timeout: out_valid stayed 1, required 0");
      end
      tick();
      tick();
   endtask

   task automatic clr();
      log_q.delete();
      done_log.delete();
      lit_q.delete();
      lit_done.delete();
   endtask

   task automatic chk_log(input string name);
      chk({name, "_nbeats"}, log_q.size(), lit_q.size());
      for (int k = 0; k < lit_q.size() && k < log_q.size(); k++)
         chk({name, "_beat"}, log_q[k], lit_q[k]);
      chk({name, "_ndone"}, done_log.size(), lit_done.size());
      for (int k = 0; k < lit_done.size() && k < done_log.size(); k++)
         chk({name, "_kept"}, done_log[k], lit_done[k]);
   endtask

   initial begin
      frame_t a;
      frame_t b;
      for (int i = 0; i < N; i++) a[i] = WIDTH'(8'h10 + i);

      rst = 1'b1;
      tick();
      en = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_index", out_index, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_kept_count", kept_count, 0);
      chk("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("release_in_ready", in_ready, 1);

      // Partial mask
      out_ready = 1'b1;
      clr();
      send(a, 8'b1010_0101);
      drain();
      lit_q.push_back(mk(8'h10, 0, 1'b0));
      lit_q.push_back(mk(8'h12, 2, 1'b0));
      lit_q.push_back(mk(8'h15, 5, 1'b0));
      lit_q.push_back(mk(8'h17, 7, 1'b1));
      lit_done.push_back(4);
      chk_log("partial");

      // Empty frame
      clr();
      send(a, 8'h00);
      chk("empty_in_ready", in_ready, 1);
      chk("empty_frame_done", frame_done, 1);
      chk("empty_kept_count", kept_count, 0);
      tick();
      tick();
      lit_done.push_back(0);
      chk_log("empty");

      // Backpressure on index 2
      clr();
      send(a, 8'hFF);
      tick();
      tick();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("bp_hold_data", out_data, 8'h12);
         chk("bp_hold_index", out_index, 2);
         tick();
      end
      out_ready = 1'b1;
      chk("bp_still_index", out_index, 2);
      tick();
      chk("bp_next_index", out_index, 3);
      chk("bp_next_data", out_data, 8'h13);
      drain();
      for (int i = 0; i < N; i++) lit_q.push_back(mk(WIDTH'(8'h10 + i), i, i == N - 1));
      lit_done.push_back(8);
      chk_log("backpressure");

      // Back-to-back: B accepted on A's last-beat edge
      clr();
      b    = a;
      b[1] = 8'hAB;
      send(a, 8'b0000_1100);
      send(b, 8'b0000_0010);
      chk("b2b_valid", out_valid, 1);
      chk("b2b_data", out_data, 8'hAB);
      chk("b2b_index", out_index, 1);
      chk("b2b_last", out_last, 1);
      chk("b2b_done", frame_done, 1);
      chk("b2b_kept", kept_count, 2);
      drain();
      lit_q.push_back(mk(8'h12, 2, 1'b0));
      lit_q.push_back(mk(8'h13, 3, 1'b1));
      lit_q.push_back(mk(8'hAB, 1, 1'b1));
      lit_done.push_back(2);
      lit_done.push_back(1);
      chk_log("b2b");

      // Reset mid-frame
      clr();
      send(a, 8'hFF);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_valid", out_valid, 0);
      chk("midrst_done", frame_done, 0);
      chk("midrst_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("midrst_release_ready", in_ready, 1);
      tick();
      tick();
      chk("midrst_no_done", done_log.size(), 0);
      clr();
      send(a, 8'b1000_0001);
      drain();
      lit_q.push_back(mk(8'h10, 0, 1'b0));
      lit_q.push_back(mk(8'h17, 7, 1'b1));
      lit_done.push_back(2);
      chk_log("after_rst");

      // Single element at the top index
      clr();
      b    = a;
      b[7] = 8'h5A;
      send(b, 8'b1000_0000);
      drain();
      lit_q.push_back(mk(8'h5A, 7, 1'b1));
      lit_done.push_back(1);
      chk_log("single_top");

      // Randomized frames with random backpressure and gaps
      rnd_or = 1'b1;
      for (int f = 0; f < 300; f++) begin
         frame_t       r;
         logic [N-1:0] k;
         int           c;
         for (int i = 0; i < N; i++) r[i] = WIDTH'($urandom);
         case ($urandom_range(0, 5))
            0:       k = '0;
            1:       k = '1;
            default: k = N'($urandom);
         endcase
         // Empty frames are offered only from an idle packer.
         if (k == '0) begin
            c = 0;
            while (out_valid && c < 300) begin
               tick();
               c++;
            end
         end
         send(r, k);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      end
      rnd_or = 1'b0;
      tick();
      out_ready = 1'b1;
      drain();

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
